// File: rtl/cred_pkg.sv
// Shared credential-store definitions: FSM states, field widths and the RAM address packing
// used by both the enrollment writer and the authentication reader.
package cred_pkg;

   localparam int CRED_ADDR_W   = 5;
   localparam int CRED_DATA_W   = 4;
   localparam int CRED_DIGITS   = 4;
   localparam int CRED_MAX_USER = 7;
   localparam int CRED_VALUE_W  = 5;
   localparam int CRED_USER_W   = 3;
   localparam int CRED_IDX_W    = $clog2(CRED_DIGITS);

   typedef logic [CRED_USER_W-1:0]  user_t;
   typedef logic [CRED_IDX_W-1:0]   idx_t;
   typedef logic [CRED_VALUE_W-1:0] value_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_USER,
      ST_GET_DIGIT,
      ST_CONFIRM,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } cred_state_e;

   function automatic logic [CRED_ADDR_W-1:0] cred_addr(input user_t user, input idx_t k);
      return {user, k};
   endfunction

endpackage

// File: rtl/credential_writer_if.sv
// Entry/strobe bundle between the admin console side and the credential writer.
interface credential_writer_if;
   import cred_pkg::*;

   logic                   start;
   logic                   button;
   value_t                 value;
   logic [CRED_ADDR_W-1:0] wr_addr;
   logic [CRED_DATA_W-1:0] wr_data;
   logic                   wr_en;
   logic                   busy;
   logic                   done;
   logic                   error;

   modport master (
      output start, button, value,
      input  wr_addr, wr_data, wr_en, busy, done, error
   );

   modport slave (
      input  start, button, value,
      output wr_addr, wr_data, wr_en, busy, done, error
   );

endinterface

// File: rtl/cred_timeout.sv
// Inactivity timer: a down-counter reloaded to CYCLES-1, expiring at terminal count zero.
module cred_timeout #(
   parameter int unsigned CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/credential_writer.sv
// Password enrollment engine: user ID + 4 digits entered twice, then a 4-word RAM burst.
// Optional inactivity timeout is built when CRED_WRITER_TIMEOUT_EN is defined.
//
// state        | meaning
// ST_IDLE      | waiting for admin start
// ST_GET_USER  | waiting for user ID press
// ST_GET_DIGIT | collecting 4 password digits into dig_buf
// ST_CONFIRM   | re-entry compared digit by digit against dig_buf
// ST_WRITE     | 4-cycle write burst, idx walks the digits
// ST_DONE      | one-cycle done pulse
// ST_ERROR     | one-cycle error pulse, entry buffer cleared
module credential_writer
   import cred_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   credential_writer_if.slave  bus
);

   cred_state_e            state, state_nxt;
   user_t                  user, user_nxt;
   idx_t                   idx, idx_nxt;
   logic [CRED_DATA_W-1:0] dig_buf [CRED_DIGITS];
   logic                   buf_wr, buf_clr;

   logic                   wr_en_q, busy_q, done_q, error_q;
   logic [CRED_ADDR_W-1:0] wr_addr_q;
   logic [CRED_DATA_W-1:0] wr_data_q;

`ifdef CRED_WRITER_TIMEOUT_EN
   logic entry_st, tmo_load, tmo_expired;

   assign entry_st = (state == ST_GET_USER) || (state == ST_GET_DIGIT) || (state == ST_CONFIRM);
   assign tmo_load = ((state == ST_IDLE) && bus.start) || (entry_st && bus.button);

   cred_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmo_load),
      .en      (entry_st),
      .expired (tmo_expired)
   );
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_nxt = state;
      user_nxt  = user;
      idx_nxt   = idx;
      buf_wr    = 1'b0;
      buf_clr   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) state_nxt = ST_GET_USER;
         end
         ST_GET_USER: begin
            if (bus.button) begin
               if (bus.value <= value_t'(CRED_MAX_USER)) begin
                  user_nxt  = bus.value[CRED_USER_W-1:0];
                  state_nxt = ST_GET_DIGIT;
               end else begin
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_GET_DIGIT: begin
            if (bus.button) begin
               if (!bus.value[CRED_VALUE_W-1]) begin
                  buf_wr  = 1'b1;
                  idx_nxt = idx + 1'b1;
                  if (idx == idx_t'(CRED_DIGITS - 1)) state_nxt = ST_CONFIRM;
               end else begin
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_CONFIRM: begin
            if (bus.button) begin
               if (bus.value == {1'b0, dig_buf[idx]}) begin
                  idx_nxt = idx + 1'b1;
                  if (idx == idx_t'(CRED_DIGITS - 1)) state_nxt = ST_WRITE;
               end else begin
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_WRITE: begin
            idx_nxt = idx + 1'b1;
            if (idx == idx_t'(CRED_DIGITS - 1)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         ST_ERROR: begin
            state_nxt = ST_IDLE;
            buf_clr   = 1'b1;
            idx_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
`ifdef CRED_WRITER_TIMEOUT_EN
      // Expiry overrides any press landing in the same cycle.
      if (entry_st && tmo_expired) begin
         state_nxt = ST_ERROR;
         user_nxt  = user;
         idx_nxt   = idx;
         buf_wr    = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         user      <= '0;
         idx       <= '0;
         for (int i = 0; i < CRED_DIGITS; i++) dig_buf[i] <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         user  <= user_nxt;
         idx   <= idx_nxt;
         if (buf_clr) begin
            for (int i = 0; i < CRED_DIGITS; i++) dig_buf[i] <= '0;
         end else if (buf_wr) begin
            dig_buf[idx] <= bus.value[CRED_DATA_W-1:0];
         end
         // Outputs decode the next state so they line up with the state they describe.
         wr_en_q <= (state_nxt == ST_WRITE);
         if (state_nxt == ST_WRITE) begin
            wr_addr_q <= cred_addr(user_nxt, idx_nxt);
            wr_data_q <= dig_buf[idx_nxt];
         end
         busy_q  <= (state_nxt != ST_IDLE);
         done_q  <= (state_nxt == ST_DONE);
         error_q <= (state_nxt == ST_ERROR);
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.error   = error_q;

endmodule

// File: tb/tb_credential_writer.sv
// Self-checking bench for credential_writer: vector table of enrollments plus corner sequences.
module tb_credential_writer;
   import cred_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   credential_writer_if bus();

   credential_writer #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [4:0] addr;
      logic [3:0] data;
   } wr_t;

   wr_t exp_q[$];

   typedef struct {
      logic [4:0] user;
      logic [4:0] dig [4];
      logic [4:0] cnf [4];
      int         err_at;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] u,
                               input logic [4:0] d0, d1, d2, d3,
                               input logic [4:0] c0, c1, c2, c3,
                               input int e);
      vec_t v;
      v.user = u;
      v.dig[0] = d0; v.dig[1] = d1; v.dig[2] = d2; v.dig[3] = d3;
      v.cnf[0] = c0; v.cnf[1] = c1; v.cnf[2] = c2; v.cnf[3] = c3;
      v.err_at = e;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] v);
      bus.button = 1'b1;
      bus.value  = v;
      tick();
      bus.button = 1'b0;
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1);
   endtask

   task automatic push_writes(input logic [2:0] u, input logic [4:0] d0, d1, d2, d3);
      wr_t w;
      w.addr = {u, 2'd0}; w.data = d0[3:0]; exp_q.push_back(w);
      w.addr = {u, 2'd1}; w.data = d1[3:0]; exp_q.push_back(w);
      w.addr = {u, 2'd2}; w.data = d2[3:0]; exp_q.push_back(w);
      w.addr = {u, 2'd3}; w.data = d3[3:0]; exp_q.push_back(w);
   endtask

   task automatic run_vec(input vec_t v);
      logic [4:0] val;
      bit errd;
      errd = 1'b0;
      start_pulse();
      for (int p = 1; p <= 9; p++) begin
         if (!errd) begin
            if (p == 1)      val = v.user;
            else if (p <= 5) val = v.dig[p-2];
            else             val = v.cnf[p-6];
            if (v.err_at == 0 && p == 9)
               push_writes(v.user[2:0], v.dig[0], v.dig[1], v.dig[2], v.dig[3]);
            press(val);
            if (p == v.err_at) begin
               chk("error_pulse", bus.error, 1);
               chk("error_busy", bus.busy, 1);
               chk("error_no_wr", bus.wr_en, 0);
               tick();
               chk("error_one_cycle", bus.error, 0);
               chk("busy_low_after_error", bus.busy, 0);
               errd = 1'b1;
            end else begin
               chk("no_error", bus.error, 0);
            end
         end
      end
      if (!errd) begin
         chk("wr_en_first", bus.wr_en, 1);
         repeat (3) tick();
         tick();
         chk("done_cycle5", bus.done, 1);
         chk("wr_en_off_at_done", bus.wr_en, 0);
         tick();
         chk("busy_low_cycle6", bus.busy, 0);
         chk("done_one_cycle", bus.done, 0);
         chk("burst_consumed", exp_q.size(), 0);
      end
   endtask

   // Scoreboard: every write strobe must match the next expected word.
   wr_t mon_w;
   always begin
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (bus.wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write addr=%0d data=%0d at %0t", bus.wr_addr, bus.wr_data, $time);
            end else begin
               mon_w = exp_q.pop_front();
               chk("wr_addr", bus.wr_addr, mon_w.addr);
               chk("wr_data", bus.wr_data, mon_w.data);
            end
         end
         if (bus.done || bus.error)
            chk("pulse_exclusive", {bus.done & bus.error, bus.done & bus.wr_en, bus.error & bus.wr_en}, 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit found;

      bus.start = 1'b0;
      bus.button = 1'b0;
      bus.value = '0;

      vecs[0] = mk(5'd5, 5'd3, 5'd9, 5'd0, 5'd15, 5'd3, 5'd9, 5'd0, 5'd15, 0);
      vecs[1] = mk(5'd1, 5'd1, 5'd2, 5'd3, 5'd4,  5'd1, 5'd2, 5'd7, 5'd0,  8);
      vecs[2] = mk(5'd7, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 0);
      vecs[3] = mk(5'd8, 5'd0, 5'd0, 5'd0, 5'd0,  5'd0, 5'd0, 5'd0, 5'd0,  1);
      vecs[4] = mk(5'd0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,  2);
      vecs[5] = mk(5'd0, 5'd1, 5'd0, 5'd0, 5'd0,  5'd1, 5'd0, 5'd0, 5'd16, 9);
      vecs[6] = mk(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,  1);
      vecs[7] = mk(5'd3, 5'd2, 5'd4, 5'd6, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0,  5);
      vecs[8] = mk(5'd6, 5'd9, 5'd8, 5'd7, 5'd6,  5'd9, 5'd8, 5'd7, 5'd6,  0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_wr_en", bus.wr_en, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done_error", {bus.done, bus.error}, 0);
      chk("reset_addr_data", {bus.wr_addr, bus.wr_data}, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", bus.busy, 0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Start and Button together: Button is dropped, the next press is the user ID.
      bus.start = 1'b1;
      bus.button = 1'b1;
      bus.value = 5'd3;
      tick();
      bus.start = 1'b0;
      bus.button = 1'b0;
      chk("start_button_busy", bus.busy, 1);
      chk("start_button_no_error", bus.error, 0);
      press(5'd2);
      press(5'd1); press(5'd2); press(5'd3); press(5'd4);
      press(5'd1); press(5'd2); press(5'd3);
      push_writes(3'd2, 5'd1, 5'd2, 5'd3, 5'd4);
      press(5'd4);
      chk("sb_wr_en_first", bus.wr_en, 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.button = 1'b1;
      bus.value = 5'd9;
      tick();
      bus.button = 1'b0;
      tick();
      tick();
      chk("write_ignores_events_done", bus.done, 1);
      tick();
      chk("write_ignores_events_busy", bus.busy, 0);
      tick();
      chk("start_in_write_ignored", bus.busy, 0);
      chk("sb_burst_consumed", exp_q.size(), 0);

      // Reset during the second write beat.
      start_pulse();
      press(5'd4);
      press(5'd5); press(5'd6); press(5'd7); press(5'd8);
      press(5'd5); press(5'd6); press(5'd7);
      push_writes(3'd4, 5'd5, 5'd6, 5'd7, 5'd8);
      press(5'd8);
      chk("rst_wr_en_beat1", bus.wr_en, 1);
      tick();
      chk("rst_wr_en_beat2", bus.wr_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_wr_en", bus.wr_en, 0);
      chk("rst_async_busy", bus.busy, 0);
      chk("rst_async_pulses", {bus.done, bus.error}, 0);
      chk("rst_async_addr_data", {bus.wr_addr, bus.wr_data}, 0);
      chk("rst_remaining_beats", exp_q.size(), 2);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rst_release_busy", bus.busy, 0);
      chk("rst_release_wr_en", bus.wr_en, 0);

      // Inactivity after the user ID press.
      start_pulse();
      press(5'd2);
      chk("tmo_no_error_at_press", bus.error, 0);
      n = 0;
      found = 1'b0;
      for (int i = 1; i <= 1000 && !found; i++) begin
         tick();
         if (bus.error) begin
            found = 1'b1;
            n = i;
         end
      end
`ifdef CRED_WRITER_TIMEOUT_EN
      chk("timeout_found", found, 1);
      chk("timeout_cycles", n, 16);
      tick();
      chk("timeout_busy_low", bus.busy, 0);
`else
      chk("no_timeout", found, 0);
      chk("no_timeout_busy", bus.busy, 1);
      press(5'd16);
      chk("exit_after_wait_error", bus.error, 1);
      tick();
      chk("exit_after_wait_busy", bus.busy, 0);
`endif

      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/credential_writer.md
# credential_writer

Enrollment engine that programs per-user passwords into the password RAM read by the authentication logic. It is the write-side counterpart to the authentication path: it collects a user ID and a 4-digit password from the same Button/Value entry used at login. It requires the password to be entered twice, then issues a 4-beat write burst into the credential store. It sits beside the access controller and is started by an admin Start pulse.

## Interface
- TIMEOUT_CYCLES, 50_000_000: inactivity limit in Clock cycles; used only with timeout compiled in.
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins an enrollment; ignored unless in IDLE.
- Button  input  1  one-cycle debounced press pulse; samples Value.
- Value  input  5  entry value; user ID or digit.
- WrAddr  output  5  credential RAM address: {user[2:0], digit_index[1:0]}.
- WrData  output  4  credential RAM data, one password digit.
- WrEn  output  1  RAM write strobe, one word per cycle.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse after a successful burst.
- Error  output  1  one-cycle pulse on a rejected entry or timeout.

## Operation
- States are IDLE, GET_USER, GET_DIGIT, CONFIRM, WRITE, DONE and ERROR.
- IDLE: on Start, go to GET_USER. Button is ignored. If Start and Button arrive together, Start wins and that Button press is discarded.
- GET_USER: on Button, Value must be ≤ 7.
  - If it is, latch user = Value[2:0] and go to GET_DIGIT.
  - If not, go to ERROR.
- GET_DIGIT: each Button press requires Value[4] = 0.
  - A valid press stores Value[3:0] into buf[idx] and increments the 2-bit idx.
  - After the 4th digit (idx wraps 3→0), go to CONFIRM.
  - A press with Value[4] = 1 goes to ERROR.
- CONFIRM: each Button press compares Value against buf[idx] (Value[4] must be 0).
  - The first mismatch goes to ERROR immediately; remaining presses are not awaited.
  - After the 4th matching digit, go to WRITE.
- WRITE: 4 consecutive cycles, WrEn = 1, WrAddr = {user, k}, WrData = buf[k], k = 0..3.
  - Button and Start are ignored throughout.
  - Go to DONE after k = 3.
- DONE: Done = 1 for one cycle, then IDLE.
- ERROR: Error = 1 for one cycle, then IDLE. buf and idx are cleared; no RAM write occurs.
- Start while Busy is ignored.

## Timing
- Reset (Reset = 0) takes effect asynchronously:
  - state goes to IDLE; WrEn, Done, Error, Busy = 0; WrAddr, WrData = 0; buf, idx, user and the timeout counter are cleared.
  - Reset during WRITE aborts the burst; WrEn drops without waiting for a clock edge.
- All outputs are registered.
- Start → Busy high at the next edge.
- Button in a state is acted on at the same edge; the state changes at that edge.
- Latency from the last CONFIRM press:
  - WrEn high on the next cycle, for 4 cycles;
  - Done on cycle 5;
  - Busy low on cycle 6.
- WrAddr and WrData hold their last values when WrEn = 0. Consumers qualify on WrEn only.
- Done and Error are never high together. Neither is high in the same cycle as WrEn.

## Configuration
- Macro CRED_WRITER_TIMEOUT_EN, when defined:
  - A counter is cleared on entry to GET_USER and on every accepted Button.
  - It counts in GET_USER, GET_DIGIT and CONFIRM.
  - When it reaches TIMEOUT_CYCLES−1, the block goes to ERROR. If a Button arrives in that same cycle, the timeout wins.
  - The counter is frozen in WRITE, DONE, ERROR and IDLE.
- Not defined: no counter is built. The entry states wait indefinitely. TIMEOUT_CYCLES is accepted but unused.

## Structure
- Shared package cred_pkg holds:
  - state enum (7 states);
  - CRED_ADDR_W = 5, CRED_DATA_W = 4, CRED_DIGITS = 4, CRED_MAX_USER = 7.
- The authentication side imports the same package so that the address packing matches.
- One sub-module, cred_timeout: a loadable, clearable counter with an expire flag. It is instantiated only under CRED_WRITER_TIMEOUT_EN.

## Test plan
- Normal enrollment:
  - Stimulus: Start, user 5, digits 3,9,0,15, confirm 3,9,0,15.
  - Required: WrEn for 4 cycles with addresses 20,21,22,23 and data 3,9,0,15. Done 1 cycle later. Busy drops.
- Confirm mismatch:
  - Stimulus: digits 1,2,3,4, confirm 1,2,7.
  - Required: Error pulse on the edge after the "7" press. No WrEn. The next Start begins a clean enrollment.
- Bad values:
  - Stimulus A: user 8. Required: Error.
  - Stimulus B: digit Value = 16. Required: Error.
  - In both cases Busy is low 2 cycles after the press.
- Simultaneous and ignored events:
  - Stimulus A: Start and Button in the same IDLE cycle. Required: the block enters GET_USER with no user latched.
  - Stimulus B: Start during WRITE. Required: ignored.
  - Stimulus C: Button during WRITE. Required: no effect on the burst.
- Reset mid-burst:
  - Stimulus: assert Reset during the 2nd WrEn cycle.
  - Required: WrEn = 0 asynchronously. All outputs at reset values. Busy = 0 after release.
- Timeout (macro defined, TIMEOUT_CYCLES = 16):
  - Stimulus: Start, user 2, then no press.
  - Required: Error 16 cycles after the last accepted press.
  - Macro undefined: no Error after 1000 idle cycles.
